aes_round_controller: RTL and testbench

- Sequencing FSM for the serial AES-128 encryption core. It sits directly upstream of the 16-byte data register unit and drives that unit's control inputs (do_sr, do_mc).
- Also drives the plaintext/feedback input mux, the round-key unit (round index, byte index, key step, rcon) and the output handshake.
- One encryption takes 98 busy cycles at 2 bytes per cycle.

---
 rtl/aes_ctrl_pkg.sv | 27 ++
 rtl/aes_rcon_gen.sv | 25 ++
 rtl/aes_round_controller.sv | 127 ++++++++++++
 tb/tb_aes_round_controller.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ctrl_pkg.sv
// rtl/aes_ctrl_pkg.sv - shared state type, constants and xtime helper for the AES-128 round controller
package aes_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SR   = 3'd2,
    PASS = 3'd3,
    OUT  = 3'd4
  } state_t;

  localparam int PASS_CYCLES = 8;
  localparam int NUM_ROUNDS  = 10;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1b;

  // Last 2-byte word index of a 16-byte pass, and the final round number.
  localparam logic [2:0] BYTE_LAST  = 3'(PASS_CYCLES - 1);
  localparam logic [3:0] ROUND_LAST = 4'(NUM_ROUNDS);

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// rtl/aes_rcon_gen.sv - round constant register for the AES-128 key schedule
module aes_rcon_gen
  import aes_ctrl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic       i_step,
  output logic [7:0] o_rcon
);

  logic [7:0] r_rcon;

  // Reload at the start of each encryption; double in GF(2^8) on every key step.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_load) begin
      r_rcon <= RCON_INIT;
    end else if (i_step) begin
      r_rcon <= xtime(r_rcon);
    end
  end

  assign o_rcon = r_rcon;

endmodule

// File: rtl/aes_round_controller.sv
// rtl/aes_round_controller.sv - sequencing FSM for the serial 2-byte/cycle AES-128 encryption core
module aes_round_controller
  import aes_ctrl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  output logic       o_busy,
  output logic       o_sel_pt,
  output logic       o_do_sr,
  output logic       o_do_mc,
  output logic [2:0] o_byte_idx,
  output logic [3:0] o_round_idx,
  output logic       o_key_step,
  output logic [7:0] o_rcon,
  output logic       o_cipher_valid,
  output logic       o_done
);

  state_t     r_state;
  state_t     w_next_state;
  logic [2:0] r_byte_idx;
  logic [3:0] r_round_idx;
  logic       r_done;
  logic       w_last_byte;
  logic       w_key_step;
  logic       w_rcon_load;

  assign w_last_byte = (r_byte_idx == BYTE_LAST);

  // A new encryption is accepted only from IDLE (including the done cycle).
  assign w_rcon_load = (r_state == IDLE) && i_start;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Word/round counters and the completion flag that marks the first IDLE cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_byte_idx  <= '0;
      r_round_idx <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= (r_state == OUT) && w_last_byte;

      // The word index restarts at every phase change, so it only wraps there.
      if (w_next_state != r_state) begin
        r_byte_idx <= '0;
      end else if (r_state inside {LOAD, PASS, OUT}) begin
        r_byte_idx <= r_byte_idx + 3'd1;
      end else begin
        r_byte_idx <= '0;
      end

      case (r_state)
        IDLE: r_round_idx <= '0;
        LOAD, PASS: begin
          if (w_last_byte && (r_round_idx != ROUND_LAST)) begin
            r_round_idx <= r_round_idx + 4'd1;
          end
        end
        OUT: begin
          if (w_last_byte) begin
            r_round_idx <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (i_start) w_next_state = LOAD;
      LOAD: if (w_last_byte) w_next_state = SR;
      SR:   w_next_state = (r_round_idx < ROUND_LAST) ? PASS : OUT;
      PASS: if (w_last_byte) w_next_state = SR;
      OUT:  if (w_last_byte) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Moore output decode; key steps happen on the last word of LOAD and PASS only.
  always_comb begin
    o_busy         = (r_state != IDLE);
    o_sel_pt       = 1'b0;
    o_do_sr        = 1'b0;
    o_do_mc        = 1'b0;
    o_cipher_valid = 1'b0;
    w_key_step     = 1'b0;
    case (r_state)
      LOAD: begin
        o_sel_pt   = 1'b1;
        w_key_step = w_last_byte;
      end
      SR:   o_do_sr = 1'b1;
      PASS: begin
        o_do_mc    = 1'b1;
        w_key_step = w_last_byte;
      end
      OUT:  o_cipher_valid = 1'b1;
      default: ;
    endcase
  end

  aes_rcon_gen u_rcon_gen (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_rcon_load),
    .i_step (w_key_step),
    .o_rcon (o_rcon)
  );

  assign o_key_step  = w_key_step;
  assign o_byte_idx  = r_byte_idx;
  assign o_round_idx = r_round_idx;
  assign o_done      = (r_state == IDLE) && r_done;

endmodule

// File: tb/tb_aes_round_controller.sv
// tb/tb_aes_round_controller.sv - self-checking bench for the AES-128 round controller
`timescale 1ns/1ps
module tb_aes_round_controller;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       start = 1'b0;
  logic       busy, sel_pt, do_sr, do_mc, key_step, cipher_valid, done;
  logic [2:0] byte_idx;
  logic [3:0] round_idx;
  logic [7:0] rcon;

  typedef struct packed {
    logic       busy;
    logic       sel_pt;
    logic       do_sr;
    logic       do_mc;
    logic [2:0] byte_idx;
    logic [3:0] round_idx;
    logic       key_step;
    logic [7:0] rcon;
    logic       cipher_valid;
    logic       done;
  } obs_t;

  int         n_run = 0;
  int         n_fail = 0;
  int         c = 0;              // cycle number within the current encryption, 0 = idle
  logic [7:0] idle_rcon = 8'h01;  // rcon value expected while idle

  always #5 clk = ~clk;

  aes_round_controller dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .o_busy         (busy),
    .o_sel_pt       (sel_pt),
    .o_do_sr        (do_sr),
    .o_do_mc        (do_mc),
    .o_byte_idx     (byte_idx),
    .o_round_idx    (round_idx),
    .o_key_step     (key_step),
    .o_rcon         (rcon),
    .o_cipher_valid (cipher_valid),
    .o_done         (done)
  );

  function automatic logic [7:0] gf_double(input logic [7:0] x);
    int v;
    v = int'(x) * 2;
    if (v > 255) v = (v - 256) ^ 27;
    return 8'(v);
  endfunction

  // Expected outputs from the published timeline: LOAD 1..8, round r SR at 9+9(r-1), OUT 91..98, done 99.
  function automatic obs_t model(input int cyc, input logic [7:0] irc);
    obs_t e;
    int   k, r, p, n;
    logic [7:0] rc;
    e = '0;
    if (cyc == 0 || cyc == 99) begin
      e.rcon = irc;
      e.done = (cyc == 99);
      return e;
    end
    e.busy = 1'b1;
    n = 0;
    for (int j = 0; j < 10; j++) if (8 + 9 * j < cyc) n++;
    rc = 8'h01;
    for (int j = 0; j < n; j++) rc = gf_double(rc);
    e.rcon = rc;
    if (cyc <= 8) begin
      e.sel_pt   = 1'b1;
      e.byte_idx = 3'(cyc - 1);
      e.key_step = (cyc == 8);
    end else begin
      k = cyc - 9;
      r = k / 9 + 1;
      p = k % 9;
      e.round_idx = 4'(r);
      if (p == 0) begin
        e.do_sr = 1'b1;
      end else if (r < 10) begin
        e.do_mc    = 1'b1;
        e.byte_idx = 3'(p - 1);
        e.key_step = (p == 8);
      end else begin
        e.cipher_valid = 1'b1;
        e.byte_idx     = 3'(p - 1);
      end
    end
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.busy = busy; o.sel_pt = sel_pt; o.do_sr = do_sr; o.do_mc = do_mc;
    o.byte_idx = byte_idx; o.round_idx = round_idx; o.key_step = key_step;
    o.rcon = rcon; o.cipher_valid = cipher_valid; o.done = done;
    return o;
  endfunction

  // Apply inputs at the falling edge, clock once, advance the reference timeline, return at the next falling edge.
  task automatic drive(input logic s, input logic r);
    start = s;
    rst   = r;
    @(posedge clk);
    if (r) begin
      c = 0;
      idle_rcon = 8'h01;
    end else if ((c == 0 || c == 99) && s) begin
      c = 1;
    end else if (c >= 1 && c <= 98) begin
      c = c + 1;
    end else begin
      c = 0;
    end
    if (c == 99) idle_rcon = 8'h6c;
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic test_reset();
    obs_t act, exp;
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    act = sample(); exp = model(c, idle_rcon);
    n_run++;
    if (act !== exp) begin n_fail++; $display("FAIL reset_state got=%h exp=%h", act, exp); end
    n_run++;
    if (rcon !== 8'h01) begin n_fail++; $display("FAIL reset_rcon got=%h exp=01", rcon); end
    drive(1'b0, 1'b0);
    act = sample(); exp = model(c, idle_rcon);
    n_run++;
    if (act !== exp) begin n_fail++; $display("FAIL reset_idle got=%h exp=%h", act, exp); end
  endtask

  task automatic test_single_run();
    obs_t act, exp;
    int n_sr = 0, n_ks = 0, n_cv = 0, n_done = 0, done_at = -1, sr_bad = 0, ks_bad = 0;
    logic [7:0] ks_rc[$];
    logic [7:0] exp_rc[10];
    exp_rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    drive(1'b1, 1'b0);
    for (int t = 1; t <= 100; t++) begin
      act = sample(); exp = model(c, idle_rcon);
      n_run++;
      if (act !== exp) begin n_fail++; $display("FAIL single_run cyc=%0d got=%h exp=%h", t, act, exp); end
      if (do_sr) begin n_sr++; if (t < 9 || (t - 9) % 9 != 0) sr_bad++; end
      if (key_step) begin n_ks++; ks_rc.push_back(rcon); if ((t - 8) % 9 != 0) ks_bad++; end
      if (cipher_valid) n_cv++;
      if (done) begin n_done++; done_at = t; end
      drive(1'b0, 1'b0);
    end
    n_run++;
    if (n_sr !== 10 || sr_bad !== 0) begin n_fail++; $display("FAIL do_sr_pulses got=%0d misplaced=%0d exp=10", n_sr, sr_bad); end
    n_run++;
    if (n_ks !== 10 || ks_bad !== 0) begin n_fail++; $display("FAIL key_step_pulses got=%0d misplaced=%0d exp=10", n_ks, ks_bad); end
    n_run++;
    if (n_cv !== 8) begin n_fail++; $display("FAIL cipher_valid_cycles got=%0d exp=8", n_cv); end
    n_run++;
    if (n_done !== 1 || done_at !== 99) begin n_fail++; $display("FAIL done_pulse count=%0d at=%0d exp=1 at 99", n_done, done_at); end
    for (int i = 0; i < 10; i++) begin
      n_run++;
      if (i >= ks_rc.size()) begin
        n_fail++; $display("FAIL rcon_seq[%0d] got=none exp=%h", i, exp_rc[i]);
      end else if (ks_rc[i] !== exp_rc[i]) begin
        n_fail++; $display("FAIL rcon_seq[%0d] got=%h exp=%h", i, ks_rc[i], exp_rc[i]);
      end
    end
  endtask

  task automatic test_ignore_start();
    obs_t act, exp;
    int n_done = 0;
    drive(1'b1, 1'b0);
    for (int t = 1; t <= 100; t++) begin
      act = sample(); exp = model(c, idle_rcon);
      n_run++;
      if (act !== exp) begin n_fail++; $display("FAIL ignore_start cyc=%0d got=%h exp=%h", t, act, exp); end
      if (done) n_done++;
      drive((t == 5 || t == 50), 1'b0);
    end
    n_run++;
    if (n_done !== 1) begin n_fail++; $display("FAIL ignore_start_dones got=%0d exp=1", n_done); end
  endtask

  task automatic test_reset_mid();
    obs_t act, exp;
    int n_done = 0, done_at = -1;
    drive(1'b1, 1'b0);
    for (int t = 1; t < 40; t++) begin
      act = sample(); exp = model(c, idle_rcon);
      n_run++;
      if (act !== exp) begin n_fail++; $display("FAIL reset_mid_pre cyc=%0d got=%h exp=%h", t, act, exp); end
      drive(1'b0, 1'b0);
    end
    drive(1'b0, 1'b1);
    act = sample();
    n_run++;
    if (act !== obs_t'({1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 8'h01, 1'b0, 1'b0})) begin
      n_fail++; $display("FAIL reset_mid_idle got=%h exp=all zero with rcon 01", act);
    end
    drive(1'b1, 1'b0);
    for (int t = 1; t <= 99; t++) begin
      act = sample(); exp = model(c, idle_rcon);
      n_run++;
      if (act !== exp) begin n_fail++; $display("FAIL reset_mid_rerun cyc=%0d got=%h exp=%h", t, act, exp); end
      if (done) begin n_done++; done_at = t; end
      drive(1'b0, 1'b0);
    end
    n_run++;
    if (n_done !== 1 || done_at !== 99) begin n_fail++; $display("FAIL reset_mid_done count=%0d at=%0d exp=1 at 99", n_done, done_at); end
  endtask

  task automatic test_back_to_back();
    obs_t act, exp;
    int d[$];
    drive(1'b1, 1'b0);
    for (int t = 1; t <= 200; t++) begin
      act = sample(); exp = model(c, idle_rcon);
      n_run++;
      if (act !== exp) begin n_fail++; $display("FAIL back_to_back cyc=%0d got=%h exp=%h", t, act, exp); end
      if (done) d.push_back(t);
      drive((t == 99), 1'b0);
    end
    n_run++;
    if (d.size() != 2 || d[0] != 99 || d[1] != 198) begin
      n_fail++; $display("FAIL back_to_back_dones got=%0d pulses first=%0d exp=2 pulses at 99,198", d.size(), (d.size() > 0) ? d[0] : -1);
    end
  endtask

  task automatic test_random();
    obs_t act, exp;
    logic s, r;
    for (int t = 0; t < 1500; t++) begin
      s = ($urandom_range(0, 5) == 0);
      r = ($urandom_range(0, 249) == 0);
      drive(s, r);
      act = sample(); exp = model(c, idle_rcon);
      n_run++;
      if (act !== exp) begin n_fail++; $display("FAIL random cyc=%0d phase=%0d got=%h exp=%h", t, c, act, exp); end
      n_run++;
      if (do_sr && do_mc) begin n_fail++; $display("FAIL random_sr_mc_exclusive cyc=%0d got=11 exp=not both", t); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_run();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
